// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector
// Description : Parametrised Mealy serial-pattern detector. Compares the last
//               N accepted bits of the serial stream x against a runtime-
//               programmable pattern and pulses y in the same cycle as the
//               final pattern bit. Overlapping or non-overlapping matching is
//               chosen by parameter. A saturating match counter with a sticky
//               saturation flag feeds the stream-monitor/debug path.
// Ports       : clk          in   1      rising-edge clock
//               reset_n      in   1      asynchronous active-low reset
//               en           in   1      sample x this cycle, else hold state
//               x            in   1      serial data bit
//               load         in   1      load pattern_in, flush history
//               pattern_in   in   N      new pattern, MSB is first bit in
//               clr_count    in   1      synchronous clear of counter/flag
//               y            out  1      Mealy match pulse
//               match_count  out  CNT_W  saturating match count
//               count_sat    out  1      sticky counter-saturated flag
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [N-1:0]     pattern_in,
  input  logic             clr_count,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  // fill counter only needs to reach N-1
  localparam int                FILL_W      = $clog2(N);
  localparam logic [FILL_W-1:0] c_fill_full = FILL_W'(N - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

  logic [N-1:0]     r_pat;
  logic [N-2:0]     r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0] r_match_count;
  logic             r_count_sat;

  logic [N-2:0]     w_shift;
  logic             w_full;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;

  // History shifted by one accepted bit; a 1-bit history is just x.
  if (N == 2) begin : g_shift_single
    assign w_shift = x;
  end else begin : g_shift_multi
    assign w_shift = {r_hist[N-3:0], x};
  end

  assign w_full    = (r_fill == c_fill_full);
  // Window is the stored N-1 bits plus the bit arriving now, so the match is
  // flagged in the same cycle as the last pattern bit.
  assign w_match   = en & ~load & w_full & ({r_hist, x} == r_pat);
  assign w_cnt_inc = r_match_count + 1'b1;

  assign y           = w_match;
  assign match_count = r_match_count;
  assign count_sat   = r_count_sat;

  // Pattern, history and fill tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
    end else if (load) begin
      r_pat  <= pattern_in;
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      if (w_match && !OVERLAP) begin
        // Non-overlapping: the next match must be built from fresh bits.
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_shift;
        if (!w_full) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  // Saturating match counter; clear takes precedence over a coincident match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_match_count <= '0;
      r_count_sat   <= 1'b0;
    end else if (clr_count) begin
      r_match_count <= '0;
      r_count_sat   <= 1'b0;
    end else if (w_match && (r_match_count != c_cnt_max)) begin
      r_match_count <= w_cnt_inc;
      if (w_cnt_inc == c_cnt_max) begin
        r_count_sat <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_detector
// Description : Self-checking bench for seq_pattern_detector. Five instances
//               with different N / OVERLAP / CNT_W share one stimulus stream
//               and are checked against a bit-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_detector;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        x;
  logic        load;
  logic [15:0] pattern_in;
  logic        clr_count;

  logic [4:0] y_v;
  logic [4:0] sat_v;
  logic [7:0] mc0;
  logic [7:0] mc1;
  logic [1:0] mc2;
  logic [3:0] mc3;
  logic [2:0] mc4;

  int errors = 0;
  int checks = 0;

  // Per-instance configuration: pattern length, overlap, counter width, reset pattern
  int          NN [5] = '{3, 3, 3, 5, 2};
  int          OV [5] = '{1, 0, 1, 1, 0};
  int          CW [5] = '{8, 8, 2, 4, 3};
  int unsigned PR [5] = '{5, 5, 5, 19, 3};

  // Reference model state: pattern, last accepted bits, count of bits since flush
  int unsigned m_pat  [5];
  int unsigned m_hist [5];
  int          m_len  [5];
  int unsigned m_cnt  [5];
  bit          m_sat  [5];

  logic [4:0] exp_y;
  logic [4:0] obs_y;

  seq_pattern_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x), .load(load),
    .pattern_in(pattern_in[2:0]), .clr_count(clr_count),
    .y(y_v[0]), .match_count(mc0), .count_sat(sat_v[0]));

  seq_pattern_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x), .load(load),
    .pattern_in(pattern_in[2:0]), .clr_count(clr_count),
    .y(y_v[1]), .match_count(mc1), .count_sat(sat_v[1]));

  seq_pattern_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x), .load(load),
    .pattern_in(pattern_in[2:0]), .clr_count(clr_count),
    .y(y_v[2]), .match_count(mc2), .count_sat(sat_v[2]));

  seq_pattern_detector #(.N(5), .PATTERN(5'b10011), .OVERLAP(1'b1), .CNT_W(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x), .load(load),
    .pattern_in(pattern_in[4:0]), .clr_count(clr_count),
    .y(y_v[3]), .match_count(mc3), .count_sat(sat_v[3]));

  seq_pattern_detector #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b0), .CNT_W(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .x(x), .load(load),
    .pattern_in(pattern_in[1:0]), .clr_count(clr_count),
    .y(y_v[4]), .match_count(mc4), .count_sat(sat_v[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned mask(int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic int unsigned dut_cnt(int i);
    int unsigned r;
    case (i)
      0:       r = mc0;
      1:       r = mc1;
      2:       r = mc2;
      3:       r = mc3;
      default: r = mc4;
    endcase
    return r;
  endfunction

  // Match when at least N-1 bits are stored and the newest N bits equal the pattern.
  function automatic logic model_y(int i, logic e, logic xv, logic ld);
    int unsigned win;
    win = ((m_hist[i] << 1) | 32'(xv)) & mask(NN[i]);
    return e && !ld && (m_len[i] >= NN[i] - 1) && (win == m_pat[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_pat[i]  = PR[i];
      m_hist[i] = 0;
      m_len[i]  = 0;
      m_cnt[i]  = 0;
      m_sat[i]  = 1'b0;
    end
  endtask

  task automatic model_clock(logic e, logic xv, logic ld, logic [15:0] pin, logic clr, logic [4:0] ys);
    int unsigned cmax;
    for (int i = 0; i < 5; i++) begin
      cmax = mask(CW[i]);
      if (ld) begin
        m_pat[i]  = 32'(pin) & mask(NN[i]);
        m_hist[i] = 0;
        m_len[i]  = 0;
      end else if (e) begin
        if (ys[i] && OV[i] == 0) begin
          m_hist[i] = 0;
          m_len[i]  = 0;
        end else begin
          m_hist[i] = ((m_hist[i] << 1) | 32'(xv)) & mask(NN[i] - 1);
          if (m_len[i] < 64) m_len[i] = m_len[i] + 1;
        end
      end
      if (clr) begin
        m_cnt[i] = 0;
        m_sat[i] = 1'b0;
      end else if (ys[i] && m_cnt[i] != cmax) begin
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == cmax) m_sat[i] = 1'b1;
      end
    end
  endtask

  // One clock: drive at negedge, sample y before the edge, advance model at the edge.
  task automatic step(logic e, logic xv, logic ld, logic [15:0] pin, logic clr);
    @(negedge clk);
    en = e; x = xv; load = ld; pattern_in = pin; clr_count = clr;
    #1;
    for (int i = 0; i < 5; i++) exp_y[i] = model_y(i, e, xv, ld);
    obs_y = y_v;
    @(posedge clk);
    model_clock(e, xv, ld, pin, clr, exp_y);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    en = 1'b0; x = 1'b0; load = 1'b0; clr_count = 1'b0; pattern_in = '0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    en = 1'b1; x = 1'b1; load = 1'b0; clr_count = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (y_v !== 5'b0) begin errors++; $display("FAIL reset_y: got %b want 00000", y_v); end
    checks++;
    if (sat_v !== 5'b0) begin errors++; $display("FAIL reset_sat: got %b want 00000", sat_v); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_cnt(i) !== 0) begin errors++; $display("FAIL reset_cnt%0d: got %0d want 0", i, dut_cnt(i)); end
    end
    @(negedge clk);
    en = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_overlap();
    logic [4:0] s1    = 5'b10101;
    logic [4:0] e_ov  = 5'b10100;
    logic [4:0] e_nov = 5'b00100;
    logic [5:0] s2    = 6'b101101;
    logic [5:0] e2    = 6'b100100;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, s1[k], 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs_y[0] !== e_ov[k]) begin errors++; $display("FAIL overlap_y bit%0d: got %b want %b", k+1, obs_y[0], e_ov[k]); end
      checks++;
      if (obs_y[1] !== e_nov[k]) begin errors++; $display("FAIL nonoverlap_y bit%0d: got %b want %b", k+1, obs_y[1], e_nov[k]); end
    end
    checks++;
    if (mc0 !== 8'd2) begin errors++; $display("FAIL overlap_count: got %0d want 2", mc0); end
    checks++;
    if (mc1 !== 8'd1) begin errors++; $display("FAIL nonoverlap_count: got %0d want 1", mc1); end
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, s2[k], 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs_y[1] !== e2[k]) begin errors++; $display("FAIL nonoverlap2_y bit%0d: got %b want %b", k+1, obs_y[1], e2[k]); end
    end
  endtask

  task automatic test_enable();
    logic [3:0] ev = 4'b1101;
    logic [3:0] xv = 4'b1001;
    logic [3:0] ey = 4'b1000;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      step(ev[k], xv[k], 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs_y[0] !== ey[k]) begin errors++; $display("FAIL enable_y cycle%0d: got %b want %b", k+1, obs_y[0], ey[k]); end
    end
  endtask

  task automatic test_load();
    logic [2:0] s_a = 3'b011;  // 1,1,0
    logic [2:0] s_b = 3'b101;  // 1,0,1
    apply_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h0006, 1'b0);
    checks++;
    if (obs_y !== 5'b0) begin errors++; $display("FAIL load_cycle_y: got %b want 00000", obs_y); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, s_a[k], 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs_y[0] !== (k == 2)) begin errors++; $display("FAIL load_match_y bit%0d: got %b want %b", k+1, obs_y[0], (k == 2)); end
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, s_b[k], 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs_y[0] !== 1'b0) begin errors++; $display("FAIL old_pattern_y bit%0d: got %b want 0", k+1, obs_y[0]); end
    end
  endtask

  task automatic test_saturate();
    logic [10:0] s = 11'b10101010101;
    apply_reset();
    for (int k = 0; k < 11; k++) step(1'b1, s[k], 1'b0, 16'h0, 1'b0);
    checks++;
    if (mc2 !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", mc2); end
    checks++;
    if (sat_v[2] !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", sat_v[2]); end
    checks++;
    if (mc0 !== 8'd5 || sat_v[0] !== 1'b0) begin errors++; $display("FAIL wide_count: got %0d/%b want 5/0", mc0, sat_v[0]); end
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if (mc2 !== 2'd0 || sat_v[2] !== 1'b0) begin errors++; $display("FAIL clr_count: got %0d/%b want 0/0", mc2, sat_v[2]); end
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    checks++;
    if (obs_y[0] !== 1'b1) begin errors++; $display("FAIL clr_match_y: got %b want 1", obs_y[0]); end
    checks++;
    if (mc0 !== 8'd0) begin errors++; $display("FAIL clr_wins: got %0d want 0", mc0); end
  endtask

  task automatic test_reset_midstream();
    logic [3:0] s = 4'b0101;  // 1,0,1,0
    apply_reset();
    for (int k = 0; k < 4; k++) step(1'b1, s[k], 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    en = 1'b0;
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (mc0 !== 8'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", mc0); end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (obs_y[0] !== 1'b0) begin errors++; $display("FAIL midreset_y: got %b want 0", obs_y[0]); end
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (obs_y[0] !== 1'b1 || mc0 !== 8'd1) begin errors++; $display("FAIL midreset_rematch: got y=%b cnt=%0d want y=1 cnt=1", obs_y[0], mc0); end
  endtask

  task automatic test_random();
    logic e, xv, ld, clr;
    logic [15:0] pin;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      e   = ($urandom_range(0, 9) < 8);
      xv  = 1'($urandom);
      ld  = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 2);
      pin = 16'($urandom);
      step(e, xv, ld, pin, clr);
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_y[i] !== exp_y[i]) begin errors++; $display("FAIL rand_y dut%0d cycle%0d: got %b want %b", i, c, obs_y[i], exp_y[i]); end
        checks++;
        if (dut_cnt(i) !== m_cnt[i]) begin errors++; $display("FAIL rand_cnt dut%0d cycle%0d: got %0d want %0d", i, c, dut_cnt(i), m_cnt[i]); end
        checks++;
        if (sat_v[i] !== m_sat[i]) begin errors++; $display("FAIL rand_sat dut%0d cycle%0d: got %b want %b", i, c, sat_v[i], m_sat[i]); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b0; x = 1'b0; load = 1'b0; clr_count = 1'b0; pattern_in = '0;
    exp_y = '0; obs_y = '0;
    model_reset();
    test_reset();
    test_overlap();
    test_enable();
    test_load();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
